// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Latency: f_out/tick change one clk edge after the wrap (odd N with DUTY50: f_out rises half a cycle later).
// Backpressure: none; loads while running are held pending until the next wrap, last write wins.
module clk_divider_prog #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter bit DUTY50      = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             f_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_cur,
   output logic             div_err
);

   localparam logic [CNT_W-1:0] C_DEF = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_pend;
   logic             r_pend_vld;
   logic             r_pos_q;
   logic             r_neg_q;
   logic             r_tick;
   logic             r_div_err;

   logic             w_load_ok;
   logic             w_load_bad;
   logic             w_wrap;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_n_nxt;
   logic [CNT_W-1:0] w_pend_nxt;
   logic             w_pend_vld_nxt;
   logic [CNT_W-1:0] w_half;
   logic             w_odd_fix;

   assign w_load_bad = div_load && (div_in < C_TWO);
   assign w_load_ok  = div_load && (div_in >= C_TWO);
   assign w_wrap     = (r_cnt == (r_n - C_ONE));

   // Next counter/divisor/pending state; while disabled the counter is held primed so re-enable wraps at once.
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_n_nxt        = r_n;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      if (!en) begin
         if (w_load_ok) begin
            w_n_nxt        = div_in;
            w_cnt_nxt      = div_in - C_ONE;
            w_pend_vld_nxt = 1'b0;
         end else begin
            w_cnt_nxt = r_n - C_ONE;
         end
      end else begin
         if (w_wrap) begin
            w_cnt_nxt = '0;
            if (r_pend_vld) begin
               w_n_nxt        = r_pend;
               w_pend_vld_nxt = 1'b0;
            end
         end else begin
            w_cnt_nxt = r_cnt + C_ONE;
         end
         // A load on the wrap edge lands in pending, so it takes effect one period later.
         if (w_load_ok) begin
            w_pend_nxt     = div_in;
            w_pend_vld_nxt = 1'b1;
         end
      end
   end

   // High-phase length ceil(N/2) for the period the counter is entering.
   assign w_half = (w_n_nxt >> 1) + {{(CNT_W-1){1'b0}}, w_n_nxt[0]};

   // Posedge state: counter, divisor, pending load and the registered output phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= C_DEF - C_ONE;
         r_n        <= C_DEF;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_pos_q    <= 1'b0;
         r_tick     <= 1'b0;
         r_div_err  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_n        <= w_n_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pos_q    <= en && (w_cnt_nxt < w_half);
         r_tick     <= en && w_wrap;
         r_div_err  <= w_load_bad;
      end
   end

   // Half-cycle delayed copy of the phase, used to trim odd ratios to an exact 50% duty.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_neg_q <= 1'b0;
      end else begin
         r_neg_q <= r_pos_q;
      end
   end

   assign w_odd_fix = DUTY50 && r_n[0];
   assign f_out     = w_odd_fix ? (r_pos_q & r_neg_q) : r_pos_q;
   assign tick      = r_tick;
   assign div_cur   = r_n;
   assign div_err   = r_div_err;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: expected periods are queued by the stimulus,
// monitors pop on each tick and each completed f_out high pulse.
`timescale 1ns/1ps
module tb_clk_divider_prog;

   localparam int W = 16;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         en       = 1'b0;
   logic         div_load = 1'b0;
   logic [W-1:0] div_in   = '0;
   logic         f_out, tick, div_err;
   logic         f_out0, tick0, div_err0;
   logic [W-1:0] div_cur, div_cur0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_cyc = 0;
   bit arm    = 1'b0;

   typedef struct { int n; int gap; } tk_t;
   typedef struct { int hi; int dly; } hi_t;
   tk_t q_tk[$];
   hi_t q_hi[$];
   hi_t q_hi0[$];

   clk_divider_prog #(.CNT_W(W), .DEFAULT_DIV(2), .DUTY50(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
      .f_out(f_out), .tick(tick), .div_cur(div_cur), .div_err(div_err));

   clk_divider_prog #(.CNT_W(W), .DEFAULT_DIV(2), .DUTY50(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
      .f_out(f_out0), .tick(tick0), .div_cur(div_cur0), .div_err(div_err0));

   always #1 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected period: divisor at its tick, cycles since previous tick (0 = first, unchecked),
   // high time in ns and rise offset for DUTY50=1, high time for DUTY50=0.
   task automatic ex(input int n, input int gap, input int hi, input int dly, input int hi0);
      q_tk.push_back(tk_t'{n: n, gap: gap});
      q_hi.push_back(hi_t'{hi: hi, dly: dly});
      q_hi0.push_back(hi_t'{hi: hi0, dly: 0});
   endtask

   task automatic drain();
      int i = 0;
      while ((q_tk.size() != 0 || q_hi.size() != 0 || q_hi0.size() != 0) && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk("drain_left", q_tk.size() + q_hi.size() + q_hi0.size(), 0);
      q_tk.delete();
      q_hi.delete();
      q_hi0.delete();
      arm = 1'b0;
   endtask

   task automatic stop_run();
      en = 1'b0;
      @(negedge clk);
      chk("dis_f_out", int'(f_out), 0);
      chk("dis_f_out0", int'(f_out0), 0);
      chk("dis_tick", int'(tick), 0);
   endtask

   task automatic load_idle(input int v);
      div_in   = W'(v);
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
   endtask

   // Tick monitor: every tick while armed must match the next queued period.
   always @(negedge clk) begin
      tk_t e;
      if (arm && tick) begin
         if (q_tk.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tick_unexpected: got tick with div_cur %0d, none expected at %0t", div_cur, $time);
         end else begin
            e = q_tk.pop_front();
            chk("tick_div_cur", int'(div_cur), e.n);
            if (e.gap != 0) chk("tick_gap", cyc - last_cyc, e.gap);
         end
         last_cyc = cyc;
      end
   end

   // High-pulse monitor for the DUTY50=1 instance.
   initial forever begin
      time t0;
      bit  a;
      hi_t e;
      @(posedge f_out);
      t0 = $time;
      a  = arm;
      @(negedge f_out);
      if (a) begin
         if (q_hi.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL hi_unexpected: got pulse at %0t, none expected", t0);
         end else begin
            e = q_hi.pop_front();
            chk("hi_ns", int'($time - t0), e.hi);
            chk("rise_dly", (t0 % 2 == 0) ? 1 : 0, e.dly);
         end
      end
   end

   // High-pulse monitor for the DUTY50=0 instance.
   initial forever begin
      time t0;
      bit  a;
      hi_t e;
      @(posedge f_out0);
      t0 = $time;
      a  = arm;
      @(negedge f_out0);
      if (a) begin
         if (q_hi0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL hi0_unexpected: got pulse at %0t, none expected", t0);
         end else begin
            e = q_hi0.pop_front();
            chk("hi0_ns", int'($time - t0), e.hi);
            chk("rise0_dly", (t0 % 2 == 0) ? 1 : 0, e.dly);
         end
      end
   end

   initial begin
      // Reset values
      repeat (4) @(negedge clk);
      chk("rst_f_out", int'(f_out), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_div_cur", int'(div_cur), 2);
      chk("rst_div_err", int'(div_err), 0);
      chk("rst_f_out0", int'(f_out0), 0);
      chk("rst_tick0", int'(tick0), 0);
      chk("rst_div_cur0", int'(div_cur0), 2);
      chk("rst_div_err0", int'(div_err0), 0);
      @(negedge clk);

      // Default divide-by-2
      arm = 1'b1;
      ex(2, 0, 2, 0, 2);
      repeat (4) ex(2, 2, 2, 0, 2);
      rst = 1'b0;
      en  = 1'b1;
      drain();
      stop_run();

      // N=6 loaded while idle
      load_idle(6);
      arm = 1'b1;
      ex(6, 0, 6, 0, 6);
      repeat (3) ex(6, 6, 6, 0, 6);
      en = 1'b1;
      drain();
      stop_run();

      // N=5: exact 50% vs posedge-only
      load_idle(5);
      arm = 1'b1;
      ex(5, 0, 5, 1, 6);
      repeat (3) ex(5, 5, 5, 1, 6);
      en = 1'b1;
      drain();
      stop_run();

      // Running reloads: 4 -> 7 at cnt==1; 9 then 3 (last wins); load of 2 on a wrap edge
      load_idle(4);
      arm = 1'b1;
      ex(4, 0, 4, 0, 4);
      ex(7, 4, 7, 1, 8);
      ex(3, 7, 3, 1, 4);
      ex(3, 3, 3, 1, 4);
      ex(2, 3, 2, 0, 2);
      ex(2, 2, 2, 0, 2);
      ex(2, 2, 2, 0, 2);
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      div_in = W'(7); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      repeat (3) @(negedge clk);
      div_in = W'(9); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      @(negedge clk);
      div_in = W'(3); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      repeat (5) @(negedge clk);
      div_in = W'(2); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      drain();
      stop_run();

      // Rejected loads of 0 and 1
      load_idle(4);
      arm = 1'b1;
      ex(4, 0, 4, 0, 4);
      repeat (3) ex(4, 4, 4, 0, 4);
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      div_in = W'(0); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      chk("err_pulse0", int'(div_err), 1);
      @(negedge clk);
      chk("err_clear0", int'(div_err), 0);
      div_in = W'(1); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      chk("err_pulse1", int'(div_err), 1);
      @(negedge clk);
      chk("err_clear1", int'(div_err), 0);
      chk("err_div_cur", int'(div_cur), 4);
      drain();
      stop_run();

      // Reset mid-period at N=6 with a pending load of 3
      load_idle(6);
      en = 1'b1;
      div_in = W'(3); div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      chk("pre_rst_f_out", int'(f_out), 1);
      chk("pre_rst_tick", int'(tick), 1);
      chk("pre_rst_div_cur", int'(div_cur), 6);
      #0.5 rst = 1'b1;
      #0.1;
      chk("arst_f_out", int'(f_out), 0);
      chk("arst_tick", int'(tick), 0);
      chk("arst_div_cur", int'(div_cur), 2);
      chk("arst_f_out0", int'(f_out0), 0);
      @(negedge clk);
      @(negedge clk);
      arm = 1'b1;
      ex(2, 0, 2, 0, 2);
      repeat (3) ex(2, 2, 2, 0, 2);
      rst = 1'b0;
      drain();
      stop_run();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
